// File: rtl/pc_fetch_stage_if.sv
//------------------------------------------------------------------------------
// Module      : pc_fetch_stage_if
// Description : Redirect/stall control, instruction-memory req/ack and decode
//               valid/ready signals of the PC/fetch stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_fetch_stage_if #(
  parameter int W = 32
);
  logic [W-1:0] next_pc_in;
  logic         redirect_in;
  logic         stall_in;
  logic         imem_req_out;
  logic [W-1:0] imem_addr_out;
  logic         imem_ack_in;
  logic [W-1:0] imem_data_in;
  logic         instr_valid_out;
  logic         decode_ready_in;
  logic [W-1:0] instr_out;
  logic [W-1:0] instr_pc_out;
  logic [W-1:0] pc_plus4_out;

  // Environment side: next-PC mux, hazard unit, instruction memory, decode.
  modport master (
    output next_pc_in, redirect_in, stall_in, imem_ack_in, imem_data_in, decode_ready_in,
    input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out, pc_plus4_out
  );

  // Fetch stage side.
  modport slave (
    input  next_pc_in, redirect_in, stall_in, imem_ack_in, imem_data_in, decode_ready_in,
    output imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out, pc_plus4_out
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : pc_fetch_stage
// Description : MIPS program counter and single-entry instruction fetch buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_stage #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  wire logic       clk,
  input  wire logic       rst_n_in,
  pc_fetch_stage_if.slave bus
);

  localparam logic [W-1:0] C_PC_STEP    = W'(4);
  localparam logic [W-1:0] C_ALIGN_MASK = ~W'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_pc;
  logic [W-1:0] r_instr;
  logic [W-1:0] r_instr_pc;
  logic         r_instr_valid;

  logic         w_take;
  logic         w_req;
  logic         w_fetch_done;
  logic [W-1:0] w_pc_plus4;
  logic [W-1:0] w_redirect_pc;

  assign w_take        = (r_state == S_FULL) && bus.decode_ready_in;
  assign w_req         = !bus.stall_in && !bus.redirect_in &&
                         ((r_state == S_FETCH) || w_take);
  assign w_fetch_done  = w_req && bus.imem_ack_in;
  assign w_pc_plus4    = r_pc + C_PC_STEP;
  assign w_redirect_pc = bus.next_pc_in & C_ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (bus.redirect_in) begin
      // Any ack in this cycle belongs to the wrong path and is discarded.
      r_state       <= S_FETCH;
      r_pc          <= w_redirect_pc;
      r_instr_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH, S_FULL: begin
          if (w_fetch_done) begin
            r_state       <= S_FULL;
            r_instr       <= bus.imem_data_in;
            r_instr_pc    <= r_pc;
            r_pc          <= w_pc_plus4;
            r_instr_valid <= 1'b1;
          end else if (w_take && !bus.stall_in) begin
            r_state       <= S_FETCH;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_out    = w_req;
  assign bus.imem_addr_out   = r_pc;
  assign bus.pc_plus4_out    = w_pc_plus4;
  assign bus.instr_valid_out = r_instr_valid;
  assign bus.instr_out       = r_instr;
  assign bus.instr_pc_out    = r_instr_pc;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_pc_fetch_stage
// Description : Directed self-checking bench for pc_fetch_stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_stage;

  logic clk;
  logic rst_n;
  int   num_checks;
  int   num_fails;

  pc_fetch_stage_if #(.W(32)) bus ();

  pc_fetch_stage #(
    .W        (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk      (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8C00_1234;
  endfunction

  assign bus.imem_data_in = mem_word(bus.imem_addr_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    num_checks = 0;
    num_fails  = 0;
    rst_n               = 1'b0;
    bus.next_pc_in      = '0;
    bus.redirect_in     = 1'b0;
    bus.stall_in        = 1'b0;
    bus.imem_ack_in     = 1'b0;
    bus.decode_ready_in = 1'b1;
    repeat (2) tick();

    // Reset state
    check_val("rst_req",    32'(bus.imem_req_out),    32'd0);
    check_val("rst_valid",  32'(bus.instr_valid_out), 32'd0);
    check_val("rst_instr",  bus.instr_out,            32'd0);
    check_val("rst_ipc",    bus.instr_pc_out,         32'd0);
    check_val("rst_addr",   bus.imem_addr_out,        32'd0);
    check_val("rst_plus4",  bus.pc_plus4_out,         32'd4);

    rst_n = 1'b1;
    #1 check_val("idle_req", 32'(bus.imem_req_out), 32'd0);
    tick();
    check_val("fetch_req",  32'(bus.imem_req_out), 32'd1);
    check_val("fetch_addr", bus.imem_addr_out,     32'd0);

    // Straight line: ack every cycle, decode always ready
    bus.imem_ack_in = 1'b1;
    tick();
    check_val("sl0_ipc",   bus.instr_pc_out,            32'd0);
    check_val("sl0_instr", bus.instr_out,               mem_word(32'd0));
    check_val("sl0_valid", 32'(bus.instr_valid_out),    32'd1);
    check_val("sl0_addr",  bus.imem_addr_out,           32'd4);
    tick();
    check_val("sl1_ipc",   bus.instr_pc_out,            32'd4);
    check_val("sl1_instr", bus.instr_out,               mem_word(32'd4));
    tick();
    check_val("sl2_ipc",   bus.instr_pc_out,            32'd8);
    tick();
    check_val("sl3_ipc",   bus.instr_pc_out,            32'd12);
    check_val("sl3_instr", bus.instr_out,               mem_word(32'd12));
    check_val("sl3_plus4", bus.pc_plus4_out,            32'd20);

    // Asynchronous reset in the middle of a cycle with a request pending
    bus.imem_ack_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_req",   32'(bus.imem_req_out),    32'd0);
    check_val("arst_valid", 32'(bus.instr_valid_out), 32'd0);
    check_val("arst_plus4", bus.pc_plus4_out,         32'd4);
    check_val("arst_addr",  bus.imem_addr_out,        32'd0);
    bus.imem_ack_in = 1'b1;
    tick();
    check_val("arst_ack_valid", 32'(bus.instr_valid_out), 32'd0);
    check_val("arst_ack_ipc",   bus.instr_pc_out,         32'd0);
    check_val("arst_ack_instr", bus.instr_out,            32'd0);
    bus.imem_ack_in = 1'b0;
    rst_n = 1'b1;
    #1 check_val("rel_req0", 32'(bus.imem_req_out), 32'd0);
    tick();

    // Slow memory: request held for three cycles, ack on the third
    check_val("slow_req1",  32'(bus.imem_req_out), 32'd1);
    check_val("slow_addr1", bus.imem_addr_out,     32'd0);
    tick();
    check_val("slow_req2",  32'(bus.imem_req_out), 32'd1);
    check_val("slow_addr2", bus.imem_addr_out,     32'd0);
    tick();
    check_val("slow_req3",  32'(bus.imem_req_out), 32'd1);
    check_val("slow_addr3", bus.imem_addr_out,     32'd0);
    bus.imem_ack_in = 1'b1;
    #1 check_val("slow_valid_pre", 32'(bus.instr_valid_out), 32'd0);
    tick();
    check_val("slow_valid", 32'(bus.instr_valid_out), 32'd1);
    check_val("slow_ipc",   bus.instr_pc_out,         32'd0);
    check_val("slow_instr", bus.instr_out,            mem_word(32'd0));

    // Backpressure: decode not ready while buffer full
    bus.decode_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("bp_req",   32'(bus.imem_req_out),    32'd0);
      check_val("bp_ipc",   bus.instr_pc_out,         32'd0);
      check_val("bp_instr", bus.instr_out,            mem_word(32'd0));
      check_val("bp_valid", 32'(bus.instr_valid_out), 32'd1);
      tick();
    end
    bus.decode_ready_in = 1'b1;
    #1;
    check_val("bp_rel_req",  32'(bus.imem_req_out), 32'd1);
    check_val("bp_rel_addr", bus.imem_addr_out,     32'd4);
    tick();
    check_val("bp_rel_ipc",   bus.instr_pc_out, 32'd4);
    check_val("bp_rel_instr", bus.instr_out,    mem_word(32'd4));

    // Stall: decode ready and ack present, but nothing moves
    bus.stall_in = 1'b1;
    #1 check_val("stall_req", 32'(bus.imem_req_out), 32'd0);
    tick();
    check_val("stall_ipc",   bus.instr_pc_out,         32'd4);
    check_val("stall_addr",  bus.imem_addr_out,        32'd8);
    check_val("stall_valid", 32'(bus.instr_valid_out), 32'd1);
    bus.stall_in = 1'b0;

    // Redirect to 0x40 with a simultaneous ack that must be dropped
    bus.redirect_in = 1'b1;
    bus.next_pc_in  = 32'h40;
    #1 check_val("redir_req", 32'(bus.imem_req_out), 32'd0);
    tick();
    check_val("redir_valid", 32'(bus.instr_valid_out), 32'd0);
    check_val("redir_addr",  bus.imem_addr_out,        32'h40);
    check_val("redir_ipc",   bus.instr_pc_out,         32'd4);
    check_val("redir_instr", bus.instr_out,            mem_word(32'd4));
    bus.redirect_in = 1'b0;
    #1 check_val("redir_req2", 32'(bus.imem_req_out), 32'd1);
    tick();
    check_val("redir_f_ipc",   bus.instr_pc_out, 32'h40);
    check_val("redir_f_instr", bus.instr_out,    mem_word(32'h40));

    // Misaligned redirect target is word-aligned
    bus.redirect_in = 1'b1;
    bus.next_pc_in  = 32'h43;
    tick();
    check_val("align_addr",  bus.imem_addr_out,        32'h40);
    check_val("align_valid", 32'(bus.instr_valid_out), 32'd0);

    // Stall and redirect together: redirect wins; then wrap at top of memory
    bus.stall_in   = 1'b1;
    bus.next_pc_in = 32'hFFFF_FFFC;
    #1 check_val("sr_req", 32'(bus.imem_req_out), 32'd0);
    tick();
    check_val("sr_addr",  bus.imem_addr_out, 32'hFFFF_FFFC);
    check_val("sr_plus4", bus.pc_plus4_out,  32'd0);
    bus.stall_in    = 1'b0;
    bus.redirect_in = 1'b0;
    #1 check_val("wrap_req", 32'(bus.imem_req_out), 32'd1);
    tick();
    check_val("wrap_ipc",   bus.instr_pc_out,  32'hFFFF_FFFC);
    check_val("wrap_instr", bus.instr_out,     mem_word(32'hFFFF_FFFC));
    check_val("wrap_addr",  bus.imem_addr_out, 32'd0);
    check_val("wrap_plus4", bus.pc_plus4_out,  32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

`default_nettype wire
